// File: rtl/dps_irq_pkg.sv
// Shared types for the DPS IRQ scheduler: FSM encoding, level constants, config entry.
package dps_irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] LEVEL_MIN = 2'd0;
    localparam logic [1:0] LEVEL_MAX = 2'd3;

    typedef struct packed {
        logic       valid;
        logic       mask;
        logic [1:0] level;
    } cfg_entry_t;

endpackage

// File: rtl/dps_irq_scheduler_if.sv
// Config, source and core-side signals of the DPS IRQ scheduler.
// master = DPS/sources/core side, slave = the scheduler.
interface dps_irq_scheduler_if #(
    parameter int P_SRC_N = 4,
    parameter int P_SRC_W = 2
);
    logic               iCFG_REQ;
    logic [P_SRC_W-1:0] iCFG_ENTRY;
    logic               iCFG_MASK;
    logic               iCFG_VALID;
    logic [1:0]         iCFG_LEVEL;
    logic [P_SRC_N-1:0] iSRC_IRQ;
    logic [P_SRC_N-1:0] oSRC_ACK;
    logic               oIRQ_VALID;
    logic [P_SRC_W-1:0] oIRQ_NUM;
    logic [1:0]         oIRQ_LEVEL;
    logic               iIRQ_ACK;
    logic               oIRQ_PENDING;

    modport master (
        output iCFG_REQ, iCFG_ENTRY, iCFG_MASK, iCFG_VALID, iCFG_LEVEL, iSRC_IRQ, iIRQ_ACK,
        input  oSRC_ACK, oIRQ_VALID, oIRQ_NUM, oIRQ_LEVEL, oIRQ_PENDING
    );

    modport slave (
        input  iCFG_REQ, iCFG_ENTRY, iCFG_MASK, iCFG_VALID, iCFG_LEVEL, iSRC_IRQ, iIRQ_ACK,
        output oSRC_ACK, oIRQ_VALID, oIRQ_NUM, oIRQ_LEVEL, oIRQ_PENDING
    );
endinterface

// File: rtl/dps_irq_sched_select.sv
// Combinational picker: highest eff level among eligible sources, ties resolved by
// scanning upward from rr_ptr with wrap (rr_ptr tied to 0 gives lowest-index-wins).
module dps_irq_sched_select #(
    parameter int P_SRC_N = 4,
    parameter int P_SRC_W = 2
) (
    input  logic [P_SRC_N-1:0]      eligible,
    input  logic [P_SRC_N-1:0][1:0] eff,
    input  logic [P_SRC_W-1:0]      rr_ptr,
    output logic [P_SRC_W-1:0]      sel,
    output logic                    found
);
    logic [1:0]         best;
    logic [P_SRC_W-1:0] idx;

    always_comb begin
        best  = 2'd0;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int n = 0; n < P_SRC_N; n++) begin
            if (eligible[n] && (eff[n] > best)) best = eff[n];
        end
        for (int k = 0; k < P_SRC_N; k++) begin
            idx = P_SRC_W'((int'(rr_ptr) + k) % P_SRC_N);
            if (!found && eligible[idx] && (eff[idx] == best)) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end
endmodule

// File: rtl/dps_irq_scheduler.sv
// Prioritising IRQ scheduler: config table, IDLE/REQ/GAP grant FSM toward the core.
// Optional round-robin tie-break: define MIST1032ISA_IRQ_SCHED_ROUND_ROBIN_EN.
module dps_irq_scheduler
    import dps_irq_pkg::*;
#(
    parameter int P_SRC_N = 4,
    parameter int P_SRC_W = 2
) (
    input  logic               iCLOCK,
    input  logic               iRESET,
    dps_irq_scheduler_if.slave bus
);
    cfg_entry_t [P_SRC_N-1:0] tbl;
    logic [P_SRC_N-1:0]       eligible;
    logic [P_SRC_N-1:0][1:0]  eff;
    logic [P_SRC_W-1:0]       sel;
    logic                     found;
    logic [P_SRC_W-1:0]       rr_ptr;
    logic [P_SRC_W-1:0]       irq_num;
    logic [1:0]               irq_level;
    state_t                   state, state_nxt;

    // Out-of-range entries are dropped so a narrow table never aliases a write.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            tbl <= '0;
        end else if (bus.iCFG_REQ && (int'(bus.iCFG_ENTRY) < P_SRC_N)) begin
            tbl[bus.iCFG_ENTRY] <= '{valid: bus.iCFG_VALID, mask: bus.iCFG_MASK,
                                     level: bus.iCFG_LEVEL};
        end
    end

    // Unconfigured entries pass through at the lowest level.
    always_comb begin
        for (int n = 0; n < P_SRC_N; n++) begin
            eligible[n] = bus.iSRC_IRQ[n] && (!tbl[n].valid || tbl[n].mask);
            eff[n]      = tbl[n].valid ? tbl[n].level : LEVEL_MIN;
        end
    end

    dps_irq_sched_select #(
        .P_SRC_N (P_SRC_N),
        .P_SRC_W (P_SRC_W)
    ) u_select (
        .eligible (eligible),
        .eff      (eff),
        .rr_ptr   (rr_ptr),
        .sel      (sel),
        .found    (found)
    );

`ifdef MIST1032ISA_IRQ_SCHED_ROUND_ROBIN_EN
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            rr_ptr <= '0;
        end else if (state == GAP) begin
            rr_ptr <= (int'(irq_num) == P_SRC_N - 1) ? '0 : irq_num + P_SRC_W'(1);
        end
    end
`else
    assign rr_ptr = '0;
`endif

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)        state_nxt = REQ;
            REQ:     if (bus.iIRQ_ACK) state_nxt = GAP;
            GAP:                       state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // Granted index/level held through REQ and kept afterwards until the next grant.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            irq_num   <= '0;
            irq_level <= LEVEL_MIN;
        end else if ((state == IDLE) && found) begin
            irq_num   <= sel;
            irq_level <= eff[sel];
        end
    end

    always_comb begin
        bus.oSRC_ACK     = '0;
        bus.oIRQ_VALID   = 1'b0;
        bus.oIRQ_PENDING = 1'b0;
        case (state)
            IDLE: if (found && !iRESET) bus.oSRC_ACK[sel] = 1'b1;
            REQ: begin
                bus.oIRQ_VALID   = 1'b1;
                bus.oIRQ_PENDING = |eligible;
            end
            GAP:     bus.oIRQ_PENDING = |eligible;
            default: ;
        endcase
    end

    assign bus.oIRQ_NUM   = irq_num;
    assign bus.oIRQ_LEVEL = irq_level;

endmodule
